bit_serial_addsub: RTL and testbench
====================================

// Module: bit_serial_addsub
// PURPOSE
//  Multi-cycle bit-serial adder/subtractor: one full-adder cell plus a carry flop,
//  one operand bit per cycle, LSB first. Area-cheap alternative to the parallel
//  adder for non-critical ALU ops; sits behind the ALU issue logic with a start/done handshake.
//  Produces the full-width sum or difference, carry-out, signed overflow and optional saturation.
// PARAMETERS
//  WIDTH   16   operand/result width in bits (>=2)
// PORTS
//  clk     in   1      clock, rising edge
//  rst     in   1      synchronous reset, active-high
//  start   in   1      request; accepted only when busy==0
//  a       in   WIDTH  operand A, sampled on the accept cycle
//  b       in   WIDTH  operand B, sampled on the accept cycle
//  sub     in   1      0: A+B, 1: A-B (A + ~B + 1); sampled on accept
//  sat     in   1      1: saturate on signed overflow; sampled on accept
//  busy    out  1      high during serial computation
//  done    out  1      one-cycle pulse: result/flags valid
//  result  out  WIDTH  sum/difference; held until the next accept
//  cout    out  1      carry out of MSB (sub: 1 = no borrow)
//  ovfl    out  1      signed overflow (carry into MSB XOR carry out of MSB)
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, result, cout, ovfl = 0; internal regs cleared.
//  FSM states: IDLE, RUN, DONE.
//   IDLE: start=1 -> latch a, b, sub, sat; bit count=0; carry=sub; go RUN.
//   RUN: each cycle bit = a[0] ^ (b[0]^sub) ^ carry;
//        carry <= (a[0]&(b[0]^sub)) | (carry&(a[0]^b[0]^sub)).
//        A/B shift right by 1; bit shifts into the result reg at MSB. Count increments.
//        Carry into MSB is captured on the MSB cycle (count==WIDTH-1).
//        After the MSB cycle (WIDTH cycles in RUN) go DONE.
//   DONE: done=1 for exactly this cycle. result, cout and ovfl are updated on entry.
//        start=1 -> accept (same as IDLE), go RUN; else go IDLE.
//  busy = (state==RUN); busy=0 in IDLE and DONE.
//  Latency: accept at cycle N -> done=1 at cycle N+WIDTH+1.
//   Throughput: one op per WIDTH+1 cycles.
//  start while busy: ignored; operands and mode are not re-sampled.
//  Saturation (sat=1 and ovfl=1):
//   - latched A MSB = 0 -> result = {0,{WIDTH-1{1}}}.
//   - latched A MSB = 1 -> result = {1,{WIDTH-1{0}}}.
//   - ovfl and cout still report the raw flags.
//  sat=0: result is the raw WIDTH-bit wrap-around value.
//  Outputs are stable between done pulses; a new accept does not clear result/flags until the next DONE.
//  rst mid-RUN or in DONE: next cycle IDLE with all outputs 0; the in-flight op is discarded with no done pulse.
//  rst has priority over start in the same cycle.
// TESTING (WIDTH=16)
//  1. a=0x0003 b=0x0004 sub=0 sat=0 start@N -> done@N+17, result=0x0007 cout=0 ovfl=0; busy high N+1..N+16.
//  2. a=0x0005 b=0x0007 sub=1 sat=0 -> result=0xFFFE cout=0 ovfl=0.
//  3. a=0x7FFF b=0x0001 sub=0: sat=0 -> result=0x8000 ovfl=1 cout=0; sat=1 -> result=0x7FFF ovfl=1.
//  4. a=0x8000 b=0x0001 sub=1: sat=0 -> result=0x7FFF cout=1 ovfl=1; sat=1 -> result=0x8000.
//  5. Op1 started (0x1111+0x2222); start pulsed mid-RUN with a=0xFFFF -> ignored, result=0x3333;
//     start held in the DONE cycle -> second op accepted, done exactly 17 cycles later.
//  6. rst during RUN at count=8 -> next cycle busy=0 done=0 result=0; no done pulse;
//     a fresh start (0x0001+0x0001) -> result=0x0002 after 17 cycles.

Source files
------------

// File: rtl/bit_serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry flop,
// one operand bit per cycle LSB first, start/done handshake.
module bit_serial_addsub #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    input  logic             sat_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             cout_o,
    output logic             ovfl_o
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, sr_q, result_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q, sub_q, sat_q, cout_q, ovfl_q;

    // Full-adder cell: B is inverted for subtract, carry flop seeded with sub.
    logic             b_eff, sum_bit, carry_nx, accept, msb_cycle, ovfl_nx;
    logic [WIDTH-1:0] raw, sat_val;

    // Datapath combinational terms for the current bit.
    always_comb begin
        b_eff     = b_q[0] ^ sub_q;
        sum_bit   = a_q[0] ^ b_eff ^ carry_q;
        carry_nx  = (a_q[0] & b_eff) | (carry_q & (a_q[0] ^ b_eff));
        accept    = start_i && (state_q != RUN);
        msb_cycle = (state_q == RUN) && (cnt_q == LAST);
        // On the MSB cycle carry_q is the carry into the MSB.
        ovfl_nx   = carry_q ^ carry_nx;
        raw       = {sum_bit, sr_q[WIDTH-1:1]};
        // a_q has been shifted so its bit 0 is the latched A MSB here.
        sat_val   = a_q[0] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_i) state_d = RUN;
            RUN:     if (cnt_q == LAST) state_d = DONE;
            DONE:    state_d = start_i ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Operand latch, serial shift and result capture on entry to DONE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_q      <= '0;
            b_q      <= '0;
            sr_q     <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            sub_q    <= 1'b0;
            sat_q    <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovfl_q   <= 1'b0;
        end else begin
            if (accept) begin
                a_q     <= a_i;
                b_q     <= b_i;
                sub_q   <= sub_i;
                sat_q   <= sat_i;
                sr_q    <= '0;
                cnt_q   <= '0;
                carry_q <= sub_i;
            end else if (state_q == RUN) begin
                a_q     <= a_q >> 1;
                b_q     <= b_q >> 1;
                sr_q    <= raw;
                cnt_q   <= cnt_q + 1'b1;
                carry_q <= carry_nx;
            end
            if (msb_cycle) begin
                result_q <= (sat_q && ovfl_nx) ? sat_val : raw;
                cout_q   <= carry_nx;
                ovfl_q   <= ovfl_nx;
            end
        end
    end

    assign busy_o   = (state_q == RUN);
    assign done_o   = (state_q == DONE);
    assign result_o = result_q;
    assign cout_o   = cout_q;
    assign ovfl_o   = ovfl_q;

endmodule

// File: tb/tb_bit_serial_addsub.sv
// Bench for bit_serial_addsub: directed cases plus random ops against an
// arithmetic reference model.
module tb_bit_serial_addsub;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst, start, sub, sat;
    logic [W-1:0] a, b;
    logic         busy, done, cout, ovfl;
    logic [W-1:0] result;

    int n_chk = 0;
    int n_fail = 0;

    bit_serial_addsub #(.WIDTH(W)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .a_i(a), .b_i(b),
        .sub_i(sub), .sat_i(sat), .busy_o(busy), .done_o(done),
        .result_o(result), .cout_o(cout), .ovfl_o(ovfl)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the operands.
    logic [W-1:0] e_res;
    logic         e_cout, e_ovfl;
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                         input logic msub, input logic msat);
        int sa, sb, sr;
        logic [W:0] ext;
        sa = $signed(ma);
        sb = $signed(mb);
        sr = msub ? sa - sb : sa + sb;
        ext = msub ? ({1'b0, ma} + {1'b0, ~mb} + 1) : ({1'b0, ma} + {1'b0, mb});
        e_cout = ext[W];
        e_ovfl = (sr > 32767) || (sr < -32768);
        if (msat && e_ovfl) e_res = (sr > 0) ? 16'h7FFF : 16'h8000;
        else                e_res = ext[W-1:0];
    endtask

    // Drive a request so it is sampled at the next posedge.
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic isub, input logic isat);
        a = ia; b = ib; sub = isub; sat = isat; start = 1'b1;
        model(ia, ib, isub, isat);
    endtask

    // From just before the accept edge: check busy over the run and the done cycle.
    // The call returns at the negedge of the done cycle with start low.
    task automatic run_check(input string tag, input int poke_at);
        @(posedge clk);
        for (int i = 1; i <= W; i++) begin
            @(negedge clk);
            start = (i == poke_at);
            if (i == poke_at) a = 16'hFFFF;
            chk({tag, ".busy"}, busy, 1'b1);
            if (i == 1 || i == W) chk({tag, ".nodone"}, done, 1'b0);
        end
        @(negedge clk);
        start = 1'b0;
        chk({tag, ".done"}, done, 1'b1);
        chk({tag, ".busy0"}, busy, 1'b0);
        chk({tag, ".res"}, result, e_res);
        chk({tag, ".cout"}, cout, e_cout);
        chk({tag, ".ovfl"}, ovfl, e_ovfl);
    endtask

    logic [W-1:0] ra, rb;
    logic         rs, rt;

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; sub = 1'b0; sat = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.busy", busy, 1'b0);
        chk("rst.done", done, 1'b0);
        chk("rst.res", result, 16'h0);
        chk("rst.flags", {cout, ovfl}, 2'b00);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases.
        issue(16'h0003, 16'h0004, 1'b0, 1'b0); run_check("t1", 0);
        @(negedge clk);
        chk("t1.after", done, 1'b0);
        issue(16'h0005, 16'h0007, 1'b1, 1'b0); run_check("t2", 0);
        issue(16'h7FFF, 16'h0001, 1'b0, 1'b0); run_check("t3a", 0);
        issue(16'h7FFF, 16'h0001, 1'b0, 1'b1); run_check("t3b", 0);
        issue(16'h8000, 16'h0001, 1'b1, 1'b0); run_check("t4a", 0);
        issue(16'h8000, 16'h0001, 1'b1, 1'b1); run_check("t4b", 0);

        // Start pulse mid-run is ignored; start in the DONE cycle is accepted.
        issue(16'h1111, 16'h2222, 1'b0, 1'b0); run_check("t5a", 5);
        chk("t5a.exp", e_res, 16'h3333);
        issue(16'h0100, 16'h0023, 1'b1, 1'b0); run_check("t5b", 0);

        // Reset mid-run at count 8 discards the op.
        issue(16'h1234, 16'h1111, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6.busy", busy, 1'b0);
        chk("t6.done", done, 1'b0);
        chk("t6.res", result, 16'h0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("t6.nodone", {busy, done}, 2'b00);
        end
        issue(16'h0001, 16'h0001, 1'b0, 1'b0); run_check("t6b", 0);

        // Random ops, sometimes back-to-back from the DONE cycle.
        for (int k = 0; k < 40; k++) begin
            ra = W'($urandom); rb = W'($urandom);
            rs = 1'($urandom); rt = 1'($urandom);
            if (k % 8 == 0) begin ra = 16'h8000 | ra; rb = 16'h7FFF & rb; rs = 1'b1; end
            if ($urandom_range(0, 1) == 0) @(negedge clk);
            issue(ra, rb, rs, rt);
            run_check("rnd", 0);
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
